mips_dmem_mmio: RTL and testbench

//  Data-side responder for the single-cycle MIPS core: answers memwrite/memaddr/memwritedata with memreaddata.

---
 rtl/mips_dmem_mmio_pkg.sv | 31 +++
 rtl/mips_dmem_mmio_if.sv | 26 ++
 rtl/mips_dmem_mmio_timer.sv | 102 ++++++++++
 rtl/mips_dmem_mmio.sv | 97 +++++++++
 tb/tb_mips_dmem_mmio.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mips_dmem_mmio_pkg.sv
// Shared definitions for the MIPS data-side responder: MMIO register offsets,
// CTRL/STATUS bit layout, timer state encoding and the default MMIO page.
package mips_dmem_mmio_pkg;

  // Default value of memaddr[31:16] that selects the MMIO page.
  localparam logic [15:0] MMIO_PAGE_DEFAULT = 16'hFFFF;

  // Word-aligned register offsets within the MMIO page.
  localparam logic [7:0] MMIO_OFF_CYCLE  = 8'h00;
  localparam logic [7:0] MMIO_OFF_LOAD   = 8'h04;
  localparam logic [7:0] MMIO_OFF_CTRL   = 8'h08;
  localparam logic [7:0] MMIO_OFF_COUNT  = 8'h0C;
  localparam logic [7:0] MMIO_OFF_STATUS = 8'h10;
  localparam logic [7:0] MMIO_OFF_GPIO   = 8'h14;

  // STATUS bit positions.
  localparam int STATUS_EXPIRED_BIT = 0;

  // Timer FSM encoding, kept as plain constants so the state register is a
  // bare logic vector.
  localparam logic [0:0] TMR_IDLE = 1'b0;
  localparam logic [0:0] TMR_RUN  = 1'b1;

  // CTRL register layout: b0 enable, b1 autoreload, b2 irq_en.
  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/mips_dmem_mmio_if.sv
// Data-port bus between the single-cycle core and its data-side responder.
// Read data is combinational from the address, so no handshake is needed.
interface mips_dmem_mmio_if;

  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;

  // Core side.
  modport master (
    output memwrite,
    output memaddr,
    output memwritedata,
    input  memreaddata
  );

  // Memory / MMIO side.
  modport slave (
    input  memwrite,
    input  memaddr,
    input  memwritedata,
    output memreaddata
  );

endinterface

// File: rtl/mips_dmem_mmio_timer.sv
// Down-counting timer: LOAD, CTRL, COUNT and STATUS registers plus the
// IDLE/RUN sequencer that reloads, counts down and flags expiry.
module mips_dmem_mmio_timer
  import mips_dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we_i,
  input  logic        ctrl_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output ctrl_t       ctrl_o,
  output logic [31:0] count_o,
  output logic        expired_o
);

  logic [31:0] load_q,    load_d;
  ctrl_t       ctrl_q,    ctrl_d;
  logic [31:0] count_q,   count_d;
  logic        expired_q, expired_d;
  logic [0:0]  state_q,   state_d;
  ctrl_t       wr_ctrl;

  assign wr_ctrl = ctrl_t'(wdata_i[2:0]);

  // Next-state for all timer registers: software writes first, then the FSM,
  // so an expiry on the same edge as a STATUS clear leaves expired set.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    load_d    = load_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    expired_d = expired_q;
    state_d   = state_q;

    if (load_we_i) load_d = wdata_i;
    if (status_we_i && wdata_i[STATUS_EXPIRED_BIT]) expired_d = 1'b0;

    case (state_q)
      TMR_IDLE: begin
        if (ctrl_we_i) begin
          ctrl_d = wr_ctrl;
          if (wr_ctrl.enable) begin
            count_d = load_q;
            state_d = TMR_RUN;
          end
        end
      end
      TMR_RUN: begin
        if (ctrl_we_i && !wr_ctrl.enable) begin
          // Software stop: COUNT freezes and this edge never expires.
          ctrl_d  = wr_ctrl;
          state_d = TMR_IDLE;
        end else begin
          // Re-enabling while running does not restart; only modes change.
          if (ctrl_we_i) begin
            ctrl_d.autoreload = wr_ctrl.autoreload;
            ctrl_d.irq_en     = wr_ctrl.irq_en;
          end
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            expired_d = 1'b1;
            if (ctrl_q.autoreload) begin
              count_d = load_q;
            end else begin
              ctrl_d.enable = 1'b0;
              state_d       = TMR_IDLE;
            end
          end
        end
      end
    endcase
  end

  // Register update with synchronous reset that aborts any run.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      load_q    <= 32'd0;
      ctrl_q    <= '0;
      count_q   <= 32'd0;
      expired_q <= 1'b0;
      state_q   <= TMR_IDLE;
    end else begin
      load_q    <= load_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      state_q   <= state_d;
    end
  end

  assign load_o    = load_q;
  assign ctrl_o    = ctrl_q;
  assign count_o   = count_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: decodes each access to
// the word RAM or the MMIO page (cycle counter, timer, GPIO) and returns read
// data combinationally in the same cycle.
module mips_dmem_mmio
  import mips_dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [15:0] MMIO_PAGE = MMIO_PAGE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_dmem_mmio_if.slave        bus,
  output logic                   timer_irq,
  output logic [7:0]             gpio_out
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   cycle_q;
  logic [7:0]    gpio_q;

  logic          is_mmio;
  logic [7:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          mmio_we;
  logic          ram_we;

  logic [31:0]   tmr_load;
  ctrl_t         tmr_ctrl;
  logic [31:0]   tmr_count;
  logic          tmr_expired;

  logic          unused_addr_bits;

  // Address decode; the RAM index drops upper bits so RAM aliases modulo depth.
  assign is_mmio  = (bus.memaddr[31:16] == MMIO_PAGE);
  assign mmio_off = {bus.memaddr[7:2], 2'b00};
  assign ram_idx  = bus.memaddr[AW+1:2];
  assign mmio_we  = bus.memwrite && is_mmio;
  assign ram_we   = bus.memwrite && !is_mmio;

  assign unused_addr_bits = ^{bus.memaddr[15:8], bus.memaddr[1:0]};

  // Word RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // plain memory and keeps its contents across a core reset.
    if (ram_we) ram_q[ram_idx] <= bus.memwritedata;
  end

  // Free-running cycle counter (read-only) and GPIO output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'd0;
      gpio_q  <= 8'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (mmio_we && mmio_off == MMIO_OFF_GPIO) gpio_q <= bus.memwritedata[7:0];
    end
  end

  mips_dmem_mmio_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .load_we_i   (mmio_we && mmio_off == MMIO_OFF_LOAD),
    .ctrl_we_i   (mmio_we && mmio_off == MMIO_OFF_CTRL),
    .status_we_i (mmio_we && mmio_off == MMIO_OFF_STATUS),
    .wdata_i     (bus.memwritedata),
    .load_o      (tmr_load),
    .ctrl_o      (tmr_ctrl),
    .count_o     (tmr_count),
    .expired_o   (tmr_expired)
  );

  // Same-cycle read mux; unmapped MMIO offsets read zero.
  always_comb begin
    bus.memreaddata = 32'd0;
    if (is_mmio) begin
      case (mmio_off)
        MMIO_OFF_CYCLE:  bus.memreaddata = cycle_q;
        MMIO_OFF_LOAD:   bus.memreaddata = tmr_load;
        MMIO_OFF_CTRL:   bus.memreaddata = {29'd0, tmr_ctrl};
        MMIO_OFF_COUNT:  bus.memreaddata = tmr_count;
        MMIO_OFF_STATUS: bus.memreaddata = {31'd0, tmr_expired};
        MMIO_OFF_GPIO:   bus.memreaddata = {24'd0, gpio_q};
        default:         bus.memreaddata = 32'd0;
      endcase
    end else begin
      bus.memreaddata = ram_q[ram_idx];
    end
  end

  assign timer_irq = tmr_expired & tmr_ctrl.irq_en;
  assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed bench for mips_dmem_mmio: RAM, cycle counter, one-shot and
// autoreload timer, GPIO/unmapped decode and reset mid-run.
module tb_mips_dmem_mmio;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_000C;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0010;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_0014;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_0040;
  localparam logic [31:0] A_RAM    = 32'h0000_0010;
  localparam logic [31:0] A_ALIAS  = 32'h0000_0110;  // A_RAM + 4*64

  logic       clk = 1'b0;
  logic       reset;
  logic       timer_irq;
  logic [7:0] gpio_out;
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;

  mips_dmem_mmio_if bus ();

  mips_dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .timer_irq (timer_irq),
    .gpio_out  (gpio_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memaddr      = a;
    bus.memwritedata = d;
    bus.memwrite     = 1'b1;
    tick();
    bus.memwrite     = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.memaddr = a;
    #1;
    check(tag, bus.memreaddata, exp);
  endtask

  initial begin
    reset            = 1'b1;
    bus.memwrite     = 1'b0;
    bus.memaddr      = 32'd0;
    bus.memwritedata = 32'd0;
    tick();
    tick();

    // Reset state
    chk_rd("rst_cycle", A_CYCLE, 32'd0);
    chk_rd("rst_ctrl", A_CTRL, 32'd0);
    chk_rd("rst_status", A_STATUS, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);

    // CYCLE counts from release, writes ignored
    reset = 1'b0;
    repeat (10) tick();
    chk_rd("cycle_10", A_CYCLE, 32'd10);
    wr(A_CYCLE, 32'h5);
    chk_rd("cycle_ro", A_CYCLE, 32'd11);

    // RAM: same-cycle read returns the old value, then new, plus aliasing
    wr(A_RAM, 32'h1111_1111);
    bus.memaddr      = A_RAM;
    bus.memwritedata = 32'hDEAD_BEEF;
    bus.memwrite     = 1'b1;
    #1;
    check("ram_old_same_cycle", bus.memreaddata, 32'h1111_1111);
    tick();
    bus.memwrite = 1'b0;
    chk_rd("ram_new", A_RAM, 32'hDEAD_BEEF);
    chk_rd("ram_alias", A_ALIAS, 32'hDEAD_BEEF);

    // One-shot: LOAD=3 -> COUNT 3,2,1,0 then expire on the 4th edge
    wr(A_LOAD, 32'd3);
    chk_rd("load_rb", A_LOAD, 32'd3);
    wr(A_CTRL, 32'h1);
    chk_rd("os_count3", A_COUNT, 32'd3);
    tick();
    chk_rd("os_count2", A_COUNT, 32'd2);
    tick();
    chk_rd("os_count1", A_COUNT, 32'd1);
    tick();
    chk_rd("os_count0", A_COUNT, 32'd0);
    chk_rd("os_not_yet", A_STATUS, 32'd0);
    chk_rd("os_ctrl_run", A_CTRL, 32'h1);
    tick();
    chk_rd("os_expired", A_STATUS, 32'd1);
    chk_rd("os_ctrl_off", A_CTRL, 32'h0);
    check("os_no_irq", {31'd0, timer_irq}, 32'd0);
    tick();
    chk_rd("os_count_hold", A_COUNT, 32'd0);
    wr(A_STATUS, 32'h1);
    chk_rd("os_w1c", A_STATUS, 32'd0);

    // Autoreload + irq: LOAD=1 -> COUNT 1,0,1,0...
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h7);
    chk_rd("ar_count1a", A_COUNT, 32'd1);
    check("ar_irq0", {31'd0, timer_irq}, 32'd0);
    tick();
    chk_rd("ar_count0a", A_COUNT, 32'd0);
    tick();
    chk_rd("ar_count1b", A_COUNT, 32'd1);
    check("ar_irq_first", {31'd0, timer_irq}, 32'd1);
    tick();
    chk_rd("ar_count0b", A_COUNT, 32'd0);
    wr(A_STATUS, 32'h1);   // edge where COUNT==0: expiry beats the clear
    chk_rd("ar_set_wins", A_STATUS, 32'd1);
    check("ar_irq_kept", {31'd0, timer_irq}, 32'd1);
    wr(A_STATUS, 32'h1);   // edge where COUNT==1: clear takes effect
    chk_rd("ar_w1c", A_STATUS, 32'd0);
    check("ar_irq_cleared", {31'd0, timer_irq}, 32'd0);
    tick();
    check("ar_irq_again", {31'd0, timer_irq}, 32'd1);
    wr(A_LOAD, 32'd2);     // new LOAD only used at the next reload
    chk_rd("ar_load_mid", A_COUNT, 32'd0);
    tick();
    chk_rd("ar_reload2", A_COUNT, 32'd2);
    wr(A_CTRL, 32'h3);     // enable stays 1: no restart, irq_en drops
    chk_rd("ar_norestart", A_COUNT, 32'd1);
    chk_rd("ar_ctrl3", A_CTRL, 32'h3);
    check("ar_irq_masked", {31'd0, timer_irq}, 32'd0);

    // GPIO and unmapped offsets
    wr(A_GPIO, 32'h1A5);
    check("gpio_out", {24'd0, gpio_out}, 32'hA5);
    chk_rd("gpio_rd", A_GPIO, 32'hA5);
    wr(A_UNMAP, 32'hFFFF_FFFF);
    chk_rd("unmapped", A_UNMAP, 32'd0);
    check("gpio_unchanged", {24'd0, gpio_out}, 32'hA5);

    // Reset in the middle of an autoreload run with irq enabled
    wr(A_CTRL, 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rd("mr_cycle", A_CYCLE, 32'd0);
    chk_rd("mr_load", A_LOAD, 32'd0);
    chk_rd("mr_ctrl", A_CTRL, 32'd0);
    chk_rd("mr_count", A_COUNT, 32'd0);
    chk_rd("mr_status", A_STATUS, 32'd0);
    chk_rd("mr_gpio", A_GPIO, 32'd0);
    check("mr_irq", {31'd0, timer_irq}, 32'd0);
    check("mr_gpio_out", {24'd0, gpio_out}, 32'd0);
    tick();
    chk_rd("mr_idle_status", A_STATUS, 32'd0);
    chk_rd("mr_idle_count", A_COUNT, 32'd0);
    chk_rd("mr_ram_kept", A_RAM, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
